// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between the requesters/FIFO side and the write arbiter.
// The arbiter uses the slave view; the requester/FIFO side uses master.
interface fifo_wr_arbiter_if #(
  parameter int DSIZE = 8,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*DSIZE-1:0] req_data;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       ack;
  logic                  busy;

  modport slave (
    input  req, req_data, wfull,
    output winc, wdata, grant, ack, busy
  );

  modport master (
    output req, req_data, wfull,
    input  winc, wdata, grant, ack, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing one async-FIFO write port among NREQ
// requesters; a grant stalled on wfull for STALL_MAX cycles is revoked.
module fifo_wr_arbiter #(
  parameter int DSIZE     = 8,
  parameter int NREQ      = 4,
  parameter int BURST     = 4,
  parameter int STALL_MAX = 16
) (
  input logic              wclk,
  input logic              wrst_n,
  fifo_wr_arbiter_if.slave bus
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int SW = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_reg, state_next;
  logic [NREQ-1:0] grant_reg, grant_next;
  logic [GW-1:0]   gidx_reg, gidx_next;
  logic [GW-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [BW-1:0]   beat_reg, beat_next;
  logic [SW-1:0]   stall_reg, stall_next;

  logic [DSIZE-1:0] slice [NREQ];
  logic             req_g, winc_c, stall_c, exit_c;
  logic [GW-1:0]    ptr_inc;
  logic [GW:0]      pick_idle, pick_exit;

  // Returns {found, index}: first requester at or after ptr, wrapping around.
  function automatic logic [GW:0] pick(input logic [NREQ-1:0] r, input logic [GW-1:0] ptr);
    logic [GW:0]   res;
    logic [GW-1:0] idx;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = GW'((int'(ptr) + k) % NREQ);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign slice[gi]   = bus.req_data[gi*DSIZE +: DSIZE];
      assign bus.ack[gi] = winc_c && (gidx_reg == GW'(gi));
    end
  endgenerate

  assign req_g   = bus.req[gidx_reg];
  assign winc_c  = (state_reg == GRANT) && req_g && !bus.wfull;
  assign stall_c = (state_reg == GRANT) && req_g && bus.wfull;
  assign ptr_inc = (int'(gidx_reg) + 1 >= NREQ) ? '0 : gidx_reg + 1'b1;
  assign exit_c  = (winc_c && (beat_reg == BW'(BURST - 1))) || !req_g ||
                   (stall_c && (stall_reg == SW'(STALL_MAX - 1)));

  assign pick_idle = pick(bus.req, rr_ptr_reg);
  // Re-arbitration on exit already sees the advanced pointer, so the leaving
  // requester only wins back the port if nobody else is asking.
  assign pick_exit = pick(bus.req, ptr_inc);

  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    gidx_next   = gidx_reg;
    rr_ptr_next = rr_ptr_reg;
    beat_next   = beat_reg;
    stall_next  = stall_reg;
    case (state_reg)
      IDLE: begin
        if (pick_idle[GW]) begin
          state_next = GRANT;
          gidx_next  = pick_idle[GW-1:0];
          grant_next = NREQ'(1) << pick_idle[GW-1:0];
          beat_next  = '0;
          stall_next = '0;
        end
      end
      GRANT: begin
        if (exit_c) begin
          rr_ptr_next = ptr_inc;
          beat_next   = '0;
          stall_next  = '0;
          if (pick_exit[GW]) begin
            gidx_next  = pick_exit[GW-1:0];
            grant_next = NREQ'(1) << pick_exit[GW-1:0];
          end else begin
            state_next = IDLE;
            grant_next = '0;
          end
        end else if (winc_c) begin
          beat_next  = beat_reg + 1'b1;
          stall_next = '0;
        end else if (stall_c) begin
          stall_next = stall_reg + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      gidx_reg   <= '0;
      rr_ptr_reg <= '0;
      beat_reg   <= '0;
      stall_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      gidx_reg   <= gidx_next;
      rr_ptr_reg <= rr_ptr_next;
      beat_reg   <= beat_next;
      stall_reg  <= stall_next;
    end
  end

  assign bus.winc  = winc_c;
  assign bus.wdata = winc_c ? slice[gidx_reg] : '0;
  assign bus.grant = grant_reg;
  assign bus.busy  = (state_reg == GRANT);
endmodule
